// File: rtl/dense_pkg.sv
// Shared types and requantisation helper for dense_layer1_2.
// RELU_EN (optional define) clamps negative requantised values to zero.
package dense_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      STORE,
      DONE
   } state_t;

   localparam int ACC_W_DEF = 24;

   // acc arrives sign-extended to 64 bits; result fits in w bits
   function automatic logic signed [63:0] requant(
      input logic signed [63:0] acc,
      input int                 shift,
      input int                 w
   );
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = acc >>> shift;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
`ifdef RELU_EN
      if (s < 0) s = '0;
`endif
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      return s;
   endfunction

endpackage

// File: rtl/dense_layer1_2_mac_unit.sv
// Signed W x W multiply-accumulate with synchronous clear and enable.
// Async active-high reset; no optional features.
module mac_unit #(
   parameter int W     = 8,
   parameter int ACC_W = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [W-1:0]     a,
   input  logic signed [W-1:0]     b,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [2*W-1:0] prod;

   assign prod = a * b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + ACC_W'(prod);
      end
   end

endmodule

// File: rtl/dense_layer1_2.sv
// Sequential dense layer: one shared MAC time-multiplexed over all neurons.
// Define RELU_EN to clamp negative outputs to zero.
module dense_layer1_2
   import dense_pkg::*;
#(
   parameter int IN_SIZE       = 256,
   parameter int OUT_SIZE      = 8,
   parameter int W             = 8,
   parameter int ACC_W         = ACC_W_DEF,
   parameter int OUT_SHIFT     = 8,
   parameter int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       weights_ready,
   input  logic [TOTAL_WEIGHTS*W-1:0] weights,
   input  logic [IN_SIZE*W-1:0]       x_in,
   output logic [OUT_SIZE*W-1:0]      y_out,
   output logic                       busy,
   output logic                       done
);

   localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
   localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

   if (ACC_W < 2 * W + $clog2(IN_SIZE)) begin : g_acc_chk
      $error("dense_layer1_2: ACC_W too narrow");
   end

   state_t state;
   state_t state_nx;

   logic [IW-1:0] i_cnt;
   logic [OW-1:0] o_cnt;
   logic          i_last;
   logic          o_last;
   logic          go;
   logic          mac_clr;
   logic          mac_en;
   int            w_idx;
   int            x_idx;

   logic signed [W-1:0]     w_cur;
   logic signed [W-1:0]     x_cur;
   logic signed [ACC_W-1:0] acc;
   logic [W-1:0]            y_new;

   assign i_last = (i_cnt == IW'(IN_SIZE - 1));
   assign o_last = (o_cnt == OW'(OUT_SIZE - 1));
   assign go     = start && weights_ready &&
                   (state == IDLE || state == DONE);

   assign w_idx = (int'(o_cnt) * IN_SIZE + int'(i_cnt)) * W;
   assign x_idx = int'(i_cnt) * W;
   assign w_cur = weights[w_idx +: W];
   assign x_cur = x_in[x_idx +: W];

   assign mac_clr = go || (state == STORE);
   assign mac_en  = (state == MAC);

   assign y_new = W'(requant(64'(acc), OUT_SHIFT, W));

   mac_unit #(
      .W     (W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (w_cur),
      .b   (x_cur),
      .acc (acc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (go) state_nx = MAC;
         MAC:   if (i_last) state_nx = STORE;
         STORE: state_nx = o_last ? DONE : MAC;
         DONE:  if (go) state_nx = MAC;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         MAC, STORE: busy = 1'b1;
         DONE:       done = 1'b1;
         default:    ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_cnt <= '0;
         o_cnt <= '0;
      end else if (go) begin
         i_cnt <= '0;
         o_cnt <= '0;
      end else if (state == MAC) begin
         i_cnt <= i_cnt + 1'b1;
      end else if (state == STORE) begin
         i_cnt <= '0;
         if (!o_last) o_cnt <= o_cnt + 1'b1;
      end
   end

   // restart from DONE wipes previous results before recompute
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_out <= '0;
      end else if (go) begin
         y_out <= '0;
      end else if (state == STORE) begin
         y_out[int'(o_cnt)*W +: W] <= y_new;
      end
   end

endmodule
